stack_cache_controller: RTL and testbench

//  Owns the operand stack of the stack processor. Keeps the top two entries (TOS, SOS) in

---
 rtl/stack_ctrl_pkg.sv | 20 ++
 rtl/stack_cache_controller.sv | 153 +++++++++++++++
 tb/tb_stack_cache_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the operand-stack cache controller: decoder op codes and FSM states.
package stack_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_DROP  = 3'd2,
        OP_DUP   = 3'd3,
        OP_OVER  = 3'd4,
        OP_SWAP  = 3'd5,
        OP_BINOP = 3'd6,
        OP_CLEAR = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/stack_cache_controller.sv
// Operand stack with TOS/SOS held in registers; deeper entries spill to and fill from a
// single-port synchronous stack RAM, one decoder op per handshake.
module stack_cache_controller
    import stack_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 8,
    parameter int RAM_WORDS  = 64,
    parameter int STACK_BASE = 0
) (
    input  logic                            CLK,
    input  logic                            reset,
    input  logic                            op_valid,
    output logic                            op_ready,
    input  logic [2:0]                      op,
    input  logic [WIDTH-1:0]                push_data,
    input  logic [WIDTH-1:0]                alu_result,
    output logic                            op_done,
    output logic [WIDTH-1:0]                top_of_stack,
    output logic [WIDTH-1:0]                second_of_stack,
    output logic [$clog2(RAM_WORDS+3)-1:0]  depth,
    output logic                            stack_err,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [WIDTH-1:0]                mem_wdata,
    output logic                            mem_we,
    input  logic [WIDTH-1:0]                mem_rdata
);

    localparam int MAX_DEPTH = RAM_WORDS + 2;
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

    localparam logic [DEPTH_W-1:0] D0   = '0;
    localparam logic [DEPTH_W-1:0] D1   = DEPTH_W'(1);
    localparam logic [DEPTH_W-1:0] D2   = DEPTH_W'(2);
    localparam logic [DEPTH_W-1:0] D3   = DEPTH_W'(3);
    localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(MAX_DEPTH);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(STACK_BASE);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   tos_q, tos_d;
    logic [WIDTH-1:0]   sos_q, sos_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  depth_a;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;

    // Spill index of the entry just below SOS is depth-2; the one refilled into SOS is depth-3.
    assign depth_a = ADDR_W'(depth_q);
    assign wr_addr = BASE_A + depth_a - ADDR_W'(2);
    assign rd_addr = BASE_A + depth_a - ADDR_W'(3);

    always_comb begin
        state_d  = state_q;
        tos_d    = tos_q;
        sos_d    = sos_q;
        depth_d  = depth_q;
        err_d    = err_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = wr_addr;

        case (state_q)
            S_IDLE: begin
                if (op_valid && !reset) begin
                    done_d = 1'b1;
                    case (op)
                        OP_PUSH, OP_DUP, OP_OVER: begin
                            if ((op == OP_DUP && depth_q == D0) ||
                                (op == OP_OVER && depth_q < D2) ||
                                depth_q == DMAX) begin
                                err_d = 1'b1;
                            end else begin
                                tos_d   = (op == OP_PUSH) ? push_data :
                                          (op == OP_DUP)  ? tos_q : sos_q;
                                sos_d   = tos_q;
                                depth_d = depth_q + D1;
                                mem_we  = (depth_q >= D2);
                            end
                        end
                        OP_SWAP: begin
                            if (depth_q < D2) begin
                                err_d = 1'b1;
                            end else begin
                                tos_d = sos_q;
                                sos_d = tos_q;
                            end
                        end
                        OP_DROP, OP_BINOP: begin
                            if ((op == OP_DROP && depth_q == D0) ||
                                (op == OP_BINOP && depth_q < D2)) begin
                                err_d = 1'b1;
                            end else begin
                                tos_d   = (op == OP_DROP) ? sos_q : alu_result;
                                depth_d = depth_q - D1;
                                if (depth_q >= D3) begin
                                    // SOS arrives from RAM next cycle; completion moves to FILL.
                                    mem_addr = rd_addr;
                                    state_d  = S_FILL;
                                    done_d   = 1'b0;
                                end else begin
                                    sos_d = '0;
                                end
                            end
                        end
                        OP_CLEAR: begin
                            tos_d   = '0;
                            sos_d   = '0;
                            depth_d = D0;
                            err_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_FILL: begin
                sos_d   = mem_rdata;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            tos_q   <= '0;
            sos_q   <= '0;
            depth_q <= D0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            sos_q   <= sos_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign op_ready        = (state_q == S_IDLE);
    assign op_done         = done_q;
    assign top_of_stack    = tos_q;
    assign second_of_stack = sos_q;
    assign depth           = depth_q;
    assign stack_err       = err_q;
    assign mem_wdata       = sos_q;

endmodule

// File: tb/tb_stack_cache_controller.sv
// Directed vector bench for stack_cache_controller with a small spill RAM (MAX_DEPTH = 4).
module tb_stack_cache_controller;

    localparam int WIDTH      = 16;
    localparam int ADDR_W     = 8;
    localparam int RAM_WORDS  = 2;
    localparam int STACK_BASE = 8;
    localparam int DEPTH_W    = $clog2(RAM_WORDS + 3);

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3,
                           OVER = 3'd4, SWAP = 3'd5, BINOP = 3'd6, CLEAR = 3'd7;

    logic                CLK = 1'b0;
    logic                reset;
    logic                op_valid;
    logic                op_ready;
    logic [2:0]          op;
    logic [WIDTH-1:0]    push_data;
    logic [WIDTH-1:0]    alu_result;
    logic                op_done;
    logic [WIDTH-1:0]    top_of_stack;
    logic [WIDTH-1:0]    second_of_stack;
    logic [DEPTH_W-1:0]  depth;
    logic                stack_err;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic                mem_we;
    logic [WIDTH-1:0]    mem_rdata;

    logic [WIDTH-1:0]    ram [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    stack_cache_controller #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .RAM_WORDS(RAM_WORDS), .STACK_BASE(STACK_BASE)
    ) dut (
        .CLK(CLK), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .push_data(push_data), .alu_result(alu_result), .op_done(op_done),
        .top_of_stack(top_of_stack), .second_of_stack(second_of_stack), .depth(depth),
        .stack_err(stack_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [2:0]        op;
        logic [WIDTH-1:0]  d;
        logic [WIDTH-1:0]  alu;
        bit                fill;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  wd;
        logic [WIDTH-1:0]  tos;
        logic [WIDTH-1:0]  sos;
        int                dep;
        bit                err;
    } vec_t;

    function automatic vec_t mkv(logic [2:0] o, logic [WIDTH-1:0] d, logic [WIDTH-1:0] alu,
                                 bit fill, bit we, logic [ADDR_W-1:0] addr,
                                 logic [WIDTH-1:0] wd, logic [WIDTH-1:0] tos,
                                 logic [WIDTH-1:0] sos, int dep, bit err);
        vec_t v;
        v.op = o; v.d = d; v.alu = alu; v.fill = fill; v.we = we; v.addr = addr;
        v.wd = wd; v.tos = tos; v.sos = sos; v.dep = dep; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge CLK);
        check({tag, ".done_idle"}, 32'(op_done), 32'd0);
        op_valid = 1'b1; op = v.op; push_data = v.d; alu_result = v.alu;
        #1;
        check({tag, ".ready"}, 32'(op_ready), 32'd1);
        check({tag, ".we"}, 32'(mem_we), 32'(v.we));
        if (v.we || v.fill) check({tag, ".addr"}, 32'(mem_addr), 32'(v.addr));
        if (v.we) check({tag, ".wdata"}, 32'(mem_wdata), 32'(v.wd));
        @(posedge CLK);
        @(negedge CLK);
        op_valid = 1'b0; op = NOP;
        #1;
        if (v.fill) begin
            check({tag, ".fill_done"}, 32'(op_done), 32'd0);
            check({tag, ".fill_ready"}, 32'(op_ready), 32'd0);
            check({tag, ".fill_we"}, 32'(mem_we), 32'd0);
            @(negedge CLK);
            #1;
        end
        check({tag, ".done"}, 32'(op_done), 32'd1);
        check({tag, ".tos"}, 32'(top_of_stack), 32'(v.tos));
        check({tag, ".sos"}, 32'(second_of_stack), 32'(v.sos));
        check({tag, ".depth"}, 32'(depth), 32'(v.dep));
        check({tag, ".err"}, 32'(stack_err), 32'(v.err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t vt [0:29];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        reset = 1'b1; op_valid = 1'b0; op = NOP; push_data = '0; alu_result = '0;

        //          op     d      alu    fill we addr wd     tos    sos    dep err
        vt[0]  = mkv(PUSH,  16'h1, 16'h0, 0, 0, 8'd0, 16'h0, 16'h1, 16'h0, 1, 0);
        vt[1]  = mkv(PUSH,  16'h2, 16'h0, 0, 0, 8'd0, 16'h0, 16'h2, 16'h1, 2, 0);
        vt[2]  = mkv(PUSH,  16'h3, 16'h0, 0, 1, 8'd8, 16'h1, 16'h3, 16'h2, 3, 0);
        vt[3]  = mkv(BINOP, 16'h0, 16'h5, 1, 0, 8'd8, 16'h0, 16'h5, 16'h1, 2, 0);
        vt[4]  = mkv(CLEAR, 16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 0);
        vt[5]  = mkv(PUSH,  16'h1, 16'h0, 0, 0, 8'd0, 16'h0, 16'h1, 16'h0, 1, 0);
        vt[6]  = mkv(PUSH,  16'h2, 16'h0, 0, 0, 8'd0, 16'h0, 16'h2, 16'h1, 2, 0);
        vt[7]  = mkv(SWAP,  16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h1, 16'h2, 2, 0);
        vt[8]  = mkv(DROP,  16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h2, 16'h0, 1, 0);
        vt[9]  = mkv(CLEAR, 16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 0);
        vt[10] = mkv(DROP,  16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 1);
        vt[11] = mkv(SWAP,  16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 1);
        vt[12] = mkv(CLEAR, 16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 0);
        vt[13] = mkv(PUSH,  16'hA, 16'h0, 0, 0, 8'd0, 16'h0, 16'hA, 16'h0, 1, 0);
        vt[14] = mkv(PUSH,  16'hD, 16'h0, 0, 0, 8'd0, 16'h0, 16'hD, 16'hA, 2, 0);
        vt[15] = mkv(PUSH,  16'hB, 16'h0, 0, 1, 8'd8, 16'hA, 16'hB, 16'hD, 3, 0);
        vt[16] = mkv(OVER,  16'h0, 16'h0, 0, 1, 8'd9, 16'hD, 16'hD, 16'hB, 4, 0);
        vt[17] = mkv(PUSH,  16'hC, 16'h0, 0, 0, 8'd0, 16'h0, 16'hD, 16'hB, 4, 1);
        vt[18] = mkv(DROP,  16'h0, 16'h0, 1, 0, 8'd9, 16'h0, 16'hB, 16'hD, 3, 1);
        vt[19] = mkv(SWAP,  16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'hD, 16'hB, 3, 1);
        vt[20] = mkv(DROP,  16'h0, 16'h0, 1, 0, 8'd8, 16'h0, 16'hB, 16'hA, 2, 1);
        vt[21] = mkv(BINOP, 16'h0, 16'h77, 0, 0, 8'd0, 16'h0, 16'h77, 16'h0, 1, 1);
        vt[22] = mkv(BINOP, 16'h0, 16'h55, 0, 0, 8'd0, 16'h0, 16'h77, 16'h0, 1, 1);
        vt[23] = mkv(DROP,  16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 1);
        vt[24] = mkv(DUP,   16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 1);
        vt[25] = mkv(OVER,  16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 1);
        vt[26] = mkv(NOP,   16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 1);
        vt[27] = mkv(CLEAR, 16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 0);
        vt[28] = mkv(PUSH,  16'h5, 16'h0, 0, 0, 8'd0, 16'h0, 16'h5, 16'h0, 1, 0);
        vt[29] = mkv(DUP,   16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h5, 16'h5, 2, 0);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        check("rst.tos", 32'(top_of_stack), 32'd0);
        check("rst.sos", 32'(second_of_stack), 32'd0);
        check("rst.depth", 32'(depth), 32'd0);
        check("rst.err", 32'(stack_err), 32'd0);
        check("rst.done", 32'(op_done), 32'd0);
        check("rst.we", 32'(mem_we), 32'd0);
        check("rst.ready", 32'(op_ready), 32'd1);

        for (int i = 0; i < 30; i++) apply(vt[i], $sformatf("v%0d", i));

        // Op held by the decoder during FILL must wait, then be taken.
        apply(mkv(CLEAR, 16'h0, 16'h0, 0, 0, 8'd0, 16'h0, 16'h0, 16'h0, 0, 0), "h0");
        apply(mkv(PUSH, 16'h1, 16'h0, 0, 0, 8'd0, 16'h0, 16'h1, 16'h0, 1, 0), "h1");
        apply(mkv(PUSH, 16'h2, 16'h0, 0, 0, 8'd0, 16'h0, 16'h2, 16'h1, 2, 0), "h2");
        apply(mkv(PUSH, 16'h3, 16'h0, 0, 1, 8'd8, 16'h1, 16'h3, 16'h2, 3, 0), "h3");
        @(negedge CLK);
        op_valid = 1'b1; op = DROP;
        @(negedge CLK);
        op = PUSH; push_data = 16'h99;
        #1;
        check("hold.ready_fill", 32'(op_ready), 32'd0);
        check("hold.we_fill", 32'(mem_we), 32'd0);
        @(negedge CLK);
        #1;
        check("hold.done_drop", 32'(op_done), 32'd1);
        check("hold.ready_back", 32'(op_ready), 32'd1);
        check("hold.tos_drop", 32'(top_of_stack), 32'h2);
        check("hold.sos_fill", 32'(second_of_stack), 32'h1);
        check("hold.depth_drop", 32'(depth), 32'd2);
        check("hold.we_push", 32'(mem_we), 32'd1);
        check("hold.addr_push", 32'(mem_addr), 32'd8);
        @(negedge CLK);
        op_valid = 1'b0; op = NOP;
        #1;
        check("hold.done_push", 32'(op_done), 32'd1);
        check("hold.tos_push", 32'(top_of_stack), 32'h99);
        check("hold.sos_push", 32'(second_of_stack), 32'h2);
        check("hold.depth_push", 32'(depth), 32'd3);
        @(negedge CLK);
        #1;
        check("hold.done_pulse", 32'(op_done), 32'd0);

        // Reset arriving while a fill is pending.
        op_valid = 1'b1; op = DROP;
        @(negedge CLK);
        op_valid = 1'b0; op = NOP; reset = 1'b1;
        #1;
        check("rstfill.ready_fill", 32'(op_ready), 32'd0);
        @(negedge CLK);
        #1;
        check("rstfill.depth", 32'(depth), 32'd0);
        check("rstfill.tos", 32'(top_of_stack), 32'd0);
        check("rstfill.sos", 32'(second_of_stack), 32'd0);
        check("rstfill.ready", 32'(op_ready), 32'd1);
        check("rstfill.done", 32'(op_done), 32'd0);
        check("rstfill.err", 32'(stack_err), 32'd0);
        reset = 1'b0;
        apply(mkv(PUSH, 16'h7, 16'h0, 0, 0, 8'd0, 16'h0, 16'h7, 16'h0, 1, 0), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
